alu_issue_controller: RTL and testbench

- Sequences one decoded ALU instruction at a time through a fixed-latency ALU and a single-write-port register file.
- Accepts the decoded fields via valid/ready and drives the register-select/constant operands to the ALU with a one-cycle issue strobe.
- Captures Y1/Y2 results and serialises up to two register writebacks onto the one write port.
- Traps invalid instructions until acknowledged.

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_issue_controller.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_controller.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : Shared types and constants for the ALU issue controller.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam int REG_SEL_W = 4;
    localparam logic [REG_SEL_W-1:0] REG_ZERO = 4'd0;

    localparam int WR_Y1 = 0;
    localparam int WR_Y2 = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB_Y1 = 3'd3,
        ST_WB_Y2 = 3'd4,
        ST_TRAP  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_controller.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_controller
// Brief    : Issues one decoded instruction to a fixed-latency ALU and
//            serialises up to two results onto a single register write port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_controller
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_LATENCY = 2,
    parameter int DATA_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_invalid,
    input  logic                 in_const_c,
    input  logic [15:0]          in_constant,
    input  logic [REG_SEL_W-1:0] in_a_sel,
    input  logic [REG_SEL_W-1:0] in_b_sel,
    input  logic [REG_SEL_W-1:0] in_c_sel,
    input  logic [REG_SEL_W-1:0] in_d_sel,
    input  logic [REG_SEL_W-1:0] in_y1_sel,
    input  logic [REG_SEL_W-1:0] in_y2_sel,
    input  logic [1:0]           in_write,
    output logic                 issue_valid,
    output logic [REG_SEL_W-1:0] issue_a_sel,
    output logic [REG_SEL_W-1:0] issue_b_sel,
    output logic [REG_SEL_W-1:0] issue_c_sel,
    output logic [REG_SEL_W-1:0] issue_d_sel,
    output logic                 issue_const_c,
    output logic [15:0]          issue_constant,
    input  logic [DATA_W-1:0]    alu_y1,
    input  logic [DATA_W-1:0]    alu_y2,
    output logic                 rf_we,
    output logic [REG_SEL_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 busy,
    output logic                 trap,
    input  logic                 trap_ack
);

    localparam logic [3:0] c_cnt_load = 4'(ALU_LATENCY - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [REG_SEL_W-1:0] r_a_sel, r_b_sel, r_c_sel, r_d_sel;
    logic [REG_SEL_W-1:0] r_y1_sel, r_y2_sel;
    logic                 r_const_c;
    logic [15:0]          r_constant;
    logic                 r_wen1, r_wen2;
    logic [DATA_W-1:0]    r_y1, r_y2;
    logic                 w_accept;
    logic                 w_sample;

    assign w_accept = (r_state == ST_IDLE) && in_valid && !in_invalid;
    // Counter reaches zero on cycle issue+ALU_LATENCY, when results are valid
    assign w_sample = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    assign issue_a_sel    = r_a_sel;
    assign issue_b_sel    = r_b_sel;
    assign issue_c_sel    = r_c_sel;
    assign issue_d_sel    = r_d_sel;
    assign issue_const_c  = r_const_c;
    assign issue_constant = r_constant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_a_sel    <= REG_ZERO;
            r_b_sel    <= REG_ZERO;
            r_c_sel    <= REG_ZERO;
            r_d_sel    <= REG_ZERO;
            r_y1_sel   <= REG_ZERO;
            r_y2_sel   <= REG_ZERO;
            r_const_c  <= 1'b0;
            r_constant <= 16'd0;
            r_wen1     <= 1'b0;
            r_wen2     <= 1'b0;
            r_y1       <= '0;
            r_y2       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a_sel    <= in_a_sel;
                r_b_sel    <= in_b_sel;
                r_c_sel    <= in_c_sel;
                r_d_sel    <= in_d_sel;
                r_y1_sel   <= in_y1_sel;
                r_y2_sel   <= in_y2_sel;
                r_const_c  <= in_const_c;
                r_constant <= in_constant;
                r_wen1     <= in_write[WR_Y1] && (in_y1_sel != REG_ZERO);
                r_wen2     <= in_write[WR_Y2] && (in_y2_sel != REG_ZERO);
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= c_cnt_load;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_sample) begin
                r_y1 <= alu_y1;
                r_y2 <= alu_y2;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        trap        = 1'b0;
        issue_valid = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = REG_ZERO;
        rf_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = in_invalid ? ST_TRAP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_valid = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_sample) begin
                    if (r_wen1) begin
                        w_state_nxt = ST_WB_Y1;
                    end else if (r_wen2) begin
                        w_state_nxt = ST_WB_Y2;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WB_Y1: begin
                rf_we       = 1'b1;
                rf_waddr    = r_y1_sel;
                rf_wdata    = r_y1;
                w_state_nxt = r_wen2 ? ST_WB_Y2 : ST_IDLE;
            end
            ST_WB_Y2: begin
                rf_we       = 1'b1;
                rf_waddr    = r_y2_sel;
                rf_wdata    = r_y2;
                w_state_nxt = ST_IDLE;
            end
            ST_TRAP: begin
                trap = 1'b1;
                if (trap_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_controller
// Brief    : Self-checking bench; one instance at latency 2 and one at latency 1
//            share all decoder-side inputs and are checked cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_controller;

    localparam int DW = 32;

    typedef struct packed {
        logic        in_ready;
        logic        busy;
        logic        trap;
        logic        issue_valid;
        logic [3:0]  a, b, c, d;
        logic        const_c;
        logic [15:0] constant;
        logic        rf_we;
        logic [3:0]  waddr;
        logic [DW-1:0] wdata;
    } obs_t;

    typedef struct packed {
        logic [3:0]  a, b, c, d;
        logic        const_c;
        logic [15:0] constant;
    } iss_t;

    typedef struct packed {
        logic [3:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        iss_t          iss;
        logic [3:0]    y1, y2;
        logic [1:0]    wr;
        logic [DW-1:0] r1, r2;
    } instr_t;

    typedef struct packed {
        instr_t     ins;
        logic [1:0] nw;
        wr_t        w0, w1;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, in_invalid = 1'b0, in_const_c = 1'b0, trap_ack = 1'b0;
    logic [15:0]   in_constant = '0;
    logic [3:0]    in_a_sel = '0, in_b_sel = '0, in_c_sel = '0, in_d_sel = '0;
    logic [3:0]    in_y1_sel = '0, in_y2_sel = '0;
    logic [1:0]    in_write = '0;
    logic [DW-1:0] alu_y1_a = '0, alu_y2_a = '0, alu_y1_b = '0, alu_y2_b = '0;

    logic          rdy_a, busy_a, trap_a, iv_a, icc_a, we_a;
    logic [3:0]    ia_a, ib_a, ic_a, id_a, wa_a;
    logic [15:0]   ik_a;
    logic [DW-1:0] wd_a;
    logic          rdy_b, busy_b, trap_b, iv_b, icc_b, we_b;
    logic [3:0]    ia_b, ib_b, ic_b, id_b, wa_b;
    logic [15:0]   ik_b;
    logic [DW-1:0] wd_b;
    obs_t          obs_a, obs_b;

    assign obs_a = {rdy_a, busy_a, trap_a, iv_a, ia_a, ib_a, ic_a, id_a, icc_a, ik_a, we_a, wa_a, wd_a};
    assign obs_b = {rdy_b, busy_b, trap_b, iv_b, ia_b, ib_b, ic_b, id_b, icc_b, ik_b, we_b, wa_b, wd_b};

    alu_issue_controller #(.ALU_LATENCY(2), .DATA_W(DW)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy_a), .in_invalid(in_invalid),
        .in_const_c(in_const_c), .in_constant(in_constant),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_c_sel(in_c_sel), .in_d_sel(in_d_sel),
        .in_y1_sel(in_y1_sel), .in_y2_sel(in_y2_sel), .in_write(in_write),
        .issue_valid(iv_a), .issue_a_sel(ia_a), .issue_b_sel(ib_a), .issue_c_sel(ic_a),
        .issue_d_sel(id_a), .issue_const_c(icc_a), .issue_constant(ik_a),
        .alu_y1(alu_y1_a), .alu_y2(alu_y2_a),
        .rf_we(we_a), .rf_waddr(wa_a), .rf_wdata(wd_a),
        .busy(busy_a), .trap(trap_a), .trap_ack(trap_ack)
    );

    alu_issue_controller #(.ALU_LATENCY(1), .DATA_W(DW)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy_b), .in_invalid(in_invalid),
        .in_const_c(in_const_c), .in_constant(in_constant),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_c_sel(in_c_sel), .in_d_sel(in_d_sel),
        .in_y1_sel(in_y1_sel), .in_y2_sel(in_y2_sel), .in_write(in_write),
        .issue_valid(iv_b), .issue_a_sel(ia_b), .issue_b_sel(ib_b), .issue_c_sel(ic_b),
        .issue_d_sel(id_b), .issue_const_c(icc_b), .issue_constant(ik_b),
        .alu_y1(alu_y1_b), .alu_y2(alu_y2_b),
        .rf_we(we_b), .rf_waddr(wa_b), .rf_wdata(wd_b),
        .busy(busy_b), .trap(trap_b), .trap_ack(trap_ack)
    );

    int   vectors = 0;
    int   miscompares = 0;
    iss_t prev_iss = '0;
    vec_t tbl[7];

    task automatic check(input obs_t act, input obs_t exp, input string name);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t idle_obs(input iss_t s);
        obs_t o;
        o = '0;
        {o.a, o.b, o.c, o.d, o.const_c, o.constant} = s;
        o.in_ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t trap_obs(input iss_t s);
        obs_t o;
        o = '0;
        {o.a, o.b, o.c, o.d, o.const_c, o.constant} = s;
        o.busy = 1'b1;
        o.trap = 1'b1;
        return o;
    endfunction

    // Cycle k after acceptance (k = 0 is the accepting cycle) for latency lat
    function automatic obs_t exp_obs(input int lat, input int k, input vec_t v);
        obs_t o;
        int   done_k;
        done_k = lat + 2 + int'(v.nw);
        o = idle_obs((k == 0) ? prev_iss : v.ins.iss);
        if (k > 0 && k < done_k) begin
            o.in_ready = 1'b0;
            o.busy     = 1'b1;
        end
        if (k == 1) o.issue_valid = 1'b1;
        if (k == lat + 2 && v.nw > 0) begin
            o.rf_we = 1'b1; o.waddr = v.w0.addr; o.wdata = v.w0.data;
        end
        if (k == lat + 3 && v.nw > 1) begin
            o.rf_we = 1'b1; o.waddr = v.w1.addr; o.wdata = v.w1.data;
        end
        return o;
    endfunction

    // Writes follow directly from the instruction: Y1 then Y2, register 0 never written
    function automatic vec_t model(input instr_t i);
        vec_t v;
        wr_t  q[$];
        v.ins = i;
        v.w0  = '0;
        v.w1  = '0;
        if (i.wr[0] && i.y1 != 4'd0) q.push_back({i.y1, i.r1});
        if (i.wr[1] && i.y2 != 4'd0) q.push_back({i.y2, i.r2});
        v.nw = 2'(q.size());
        if (q.size() > 0) v.w0 = q[0];
        if (q.size() > 1) v.w1 = q[1];
        return v;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.iss = iss_t'({$urandom, $urandom});
        i.y1  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        i.y2  = ($urandom_range(0, 3) == 0) ? i.y1 : 4'($urandom);
        i.wr  = 2'($urandom);
        i.r1  = $urandom;
        i.r2  = $urandom;
        return i;
    endfunction

    function automatic vec_t mk(input iss_t s, input logic [3:0] y1, input logic [3:0] y2,
                                input logic [1:0] wr, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                                input logic [1:0] nw, input logic [3:0] wa0, input logic [DW-1:0] wd0,
                                input logic [3:0] wa1, input logic [DW-1:0] wd1);
        vec_t v;
        v.ins = {s, y1, y2, wr, r1, r2};
        v.nw  = nw;
        v.w0  = {wa0, wd0};
        v.w1  = {wa1, wd1};
        return v;
    endfunction

    task automatic drive_fields(input instr_t i);
        {in_a_sel, in_b_sel, in_c_sel, in_d_sel, in_const_c, in_constant} = i.iss;
        in_y1_sel = i.y1;
        in_y2_sel = i.y2;
        in_write  = i.wr;
    endtask

    // Entered and left at a negedge with both instances idle
    task automatic run_vec(input vec_t v, input bit noise, input string name);
        int kend;
        kend = 4 + int'(v.nw);
        for (int k = 0; k < kend; k++) begin
            check(obs_a, exp_obs(2, k, v), $sformatf("%s_L2_k%0d", name, k));
            check(obs_b, exp_obs(1, k, v), $sformatf("%s_L1_k%0d", name, k));
            in_valid   = (k == 0);
            in_invalid = 1'b0;
            trap_ack   = noise ? 1'($urandom) : 1'b0;
            if (k == 0) begin
                drive_fields(v.ins);
            end else if (noise && k <= 2 + int'(v.nw)) begin
                drive_fields(rand_instr());
                in_valid   = 1'($urandom);
                in_invalid = 1'($urandom);
            end
            alu_y1_a = (k == 3) ? v.ins.r1 : $urandom;
            alu_y2_a = (k == 3) ? v.ins.r2 : $urandom;
            alu_y1_b = (k == 2) ? v.ins.r1 : $urandom;
            alu_y2_b = (k == 2) ? v.ins.r2 : $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        trap_ack = 1'b0;
        prev_iss = v.ins.iss;
    endtask

    initial begin
        tbl[0] = mk({4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 16'h1234}, 4'd3, 4'd5, 2'b11, 32'hA, 32'hB,
                    2'd2, 4'd3, 32'hA, 4'd5, 32'hB);
        tbl[1] = mk({4'd6, 4'd7, 4'd8, 4'd9, 1'b1, 16'hBEEF}, 4'd0, 4'd7, 2'b11, 32'h11111111, 32'h22222222,
                    2'd1, 4'd7, 32'h22222222, 4'd0, 32'h0);
        tbl[2] = mk({4'd15, 4'd14, 4'd13, 4'd12, 1'b1, 16'hFFFF}, 4'd2, 4'd3, 2'b00, 32'h5, 32'h6,
                    2'd0, 4'd0, 32'h0, 4'd0, 32'h0);
        tbl[3] = mk({4'd4, 4'd4, 4'd4, 4'd4, 1'b0, 16'h0001}, 4'd4, 4'd4, 2'b11, 32'hCAFE0001, 32'hCAFE0002,
                    2'd2, 4'd4, 32'hCAFE0001, 4'd4, 32'hCAFE0002);
        tbl[4] = mk({4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 16'h8000}, 4'd9, 4'd10, 2'b01, 32'h12345678, 32'h9ABCDEF0,
                    2'd1, 4'd9, 32'h12345678, 4'd0, 32'h0);
        tbl[5] = mk({4'd3, 4'd5, 4'd7, 4'd9, 1'b0, 16'h00A5}, 4'd12, 4'd0, 2'b10, 32'h77, 32'h88,
                    2'd0, 4'd0, 32'h0, 4'd0, 32'h0);
        tbl[6] = mk({4'd8, 4'd9, 4'd10, 4'd11, 1'b1, 16'h7FFF}, 4'd15, 4'd15, 2'b10, 32'h1, 32'hFFFFFFFF,
                    2'd1, 4'd15, 32'hFFFFFFFF, 4'd0, 32'h0);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check(obs_a, idle_obs('0), "reset_L2");
        check(obs_b, idle_obs('0), "reset_L1");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0, $sformatf("dir%0d", i));

        // Invalid instruction traps until acknowledged; valid requests meanwhile are ignored
        drive_fields(rand_instr());
        in_valid   = 1'b1;
        in_invalid = 1'b1;
        trap_ack   = 1'b0;
        @(negedge clk);
        in_invalid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            check(obs_a, trap_obs(prev_iss), $sformatf("trap_hold_L2_%0d", t));
            check(obs_b, trap_obs(prev_iss), $sformatf("trap_hold_L1_%0d", t));
            drive_fields(rand_instr());
            @(negedge clk);
        end
        check(obs_a, trap_obs(prev_iss), "trap_pre_ack_L2");
        check(obs_b, trap_obs(prev_iss), "trap_pre_ack_L1");
        in_valid = 1'b0;
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        check(obs_a, idle_obs(prev_iss), "trap_release_L2");
        check(obs_b, idle_obs(prev_iss), "trap_release_L1");
        run_vec(tbl[0], 1'b0, "after_trap");

        // Reset while both instances sit in WAIT abandons the instruction
        drive_fields(tbl[3].ins);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        prev_iss = '0;
        for (int t = 0; t < 6; t++) begin
            check(obs_a, idle_obs('0), $sformatf("reset_wait_L2_%0d", t));
            check(obs_b, idle_obs('0), $sformatf("reset_wait_L1_%0d", t));
            alu_y1_a = $urandom; alu_y2_a = $urandom;
            alu_y1_b = $urandom; alu_y2_b = $urandom;
            @(negedge clk);
        end

        for (int n = 0; n < 60; n++) run_vec(model(rand_instr()), 1'b1, $sformatf("rnd%0d", n));

        check(obs_a, idle_obs(prev_iss), "final_L2");
        check(obs_b, idle_obs(prev_iss), "final_L1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
